// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the chunked add/subtract unit.
package add_sub_pkg;

    // Widest operand the saturation helpers can describe.
    localparam int unsigned SAT_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Largest positive two's-complement value of the given width, zero-extended.
    function automatic logic [SAT_W-1:0] sat_max(input int unsigned width);
        return (SAT_W'(1) << (width - 1)) - SAT_W'(1);
    endfunction

    // Most negative two's-complement value of the given width, zero-extended.
    function automatic logic [SAT_W-1:0] sat_min(input int unsigned width);
        return SAT_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK_WIDTH-bit adder slice with carry in/out.
module adder_chunk #(
    parameter int unsigned CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [CHUNK_WIDTH-1:0] sum,
    output logic                   cout
);

    // Plain ripple add; the extra top bit becomes the carry out.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK_WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/chunked_add_sub_unit.sv
// Multi-cycle add/subtract: one CHUNK_WIDTH slice per cycle, carry kept in a
// register, flags and optional signed saturation computed on the last slice.
module chunked_add_sub_unit
    import add_sub_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned CHUNK_WIDTH = 8,
    parameter bit          SATURATE_EN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [BUS_WIDTH-1:0] i_operand1,
    input  logic [BUS_WIDTH-1:0] i_operand2,
    input  logic                 i_sub,
    input  logic                 i_saturate,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [BUS_WIDTH-1:0] o_result,
    output logic                 o_carry_flag,
    output logic                 o_overflow_flag,
    output logic                 o_zero_flag,
    output logic                 o_negative_flag
);

    localparam int unsigned NCHUNK = BUS_WIDTH / CHUNK_WIDTH;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [BUS_WIDTH-1:0] SAT_MAX = BUS_WIDTH'(sat_max(BUS_WIDTH));
    localparam logic [BUS_WIDTH-1:0] SAT_MIN = BUS_WIDTH'(sat_min(BUS_WIDTH));

    if (BUS_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
        $error("CHUNK_WIDTH (%0d) must divide BUS_WIDTH (%0d)", CHUNK_WIDTH, BUS_WIDTH);
    end

    state_e                               state_q, state_d;
    logic [NCHUNK-1:0][CHUNK_WIDTH-1:0]   a_q, a_d;
    logic [NCHUNK-1:0][CHUNK_WIDTH-1:0]   b_q, b_d;
    logic [NCHUNK-1:0][CHUNK_WIDTH-1:0]   sum_q, sum_d;
    logic                                 carry_q, carry_d;
    logic                                 sat_q, sat_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [BUS_WIDTH-1:0]                 result_q, result_d;
    logic                                 c_flag_q, c_flag_d;
    logic                                 v_flag_q, v_flag_d;
    logic                                 z_flag_q, z_flag_d;
    logic                                 n_flag_q, n_flag_d;
    logic                                 ready_q, ready_d;
    logic                                 valid_q, valid_d;

    logic [CHUNK_WIDTH-1:0]               chunk_a, chunk_b, chunk_sum;
    logic                                 chunk_cout;
    logic [BUS_WIDTH-1:0]                 raw_word, final_word;
    logic                                 a_msb, b_msb, overflow, sat_hit;

    adder_chunk #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_adder (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // Next-state, datapath and flag computation.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        sat_d    = sat_q;
        idx_d    = idx_q;
        result_d = result_q;
        c_flag_d = c_flag_q;
        v_flag_d = v_flag_q;
        z_flag_d = z_flag_q;
        n_flag_d = n_flag_q;
        ready_d  = ready_q;
        valid_d  = valid_q;

        chunk_a = a_q[idx_q];
        chunk_b = b_q[idx_q];

        // Word as it will look once the current slice is written back.
        sum_d[idx_q] = (state_q == CALC) ? chunk_sum : sum_q[idx_q];
        raw_word     = sum_d;

        a_msb      = a_q[NCHUNK-1][CHUNK_WIDTH-1];
        b_msb      = b_q[NCHUNK-1][CHUNK_WIDTH-1];
        overflow   = (a_msb == b_msb) && (raw_word[BUS_WIDTH-1] != a_msb);
        sat_hit    = SATURATE_EN && sat_q && overflow;
        final_word = sat_hit ? (a_msb ? SAT_MIN : SAT_MAX) : raw_word;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_operand1;
                    b_d     = i_operand2 ^ {BUS_WIDTH{i_sub}};
                    carry_d = i_sub;
                    sat_d   = i_saturate && SATURATE_EN;
                    idx_d   = '0;
                    ready_d = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                carry_d = chunk_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    result_d = final_word;
                    c_flag_d = chunk_cout;
                    v_flag_d = overflow;
                    z_flag_d = (final_word == '0);
                    n_flag_d = final_word[BUS_WIDTH-1];
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            sat_q    <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            c_flag_q <= 1'b0;
            v_flag_q <= 1'b0;
            z_flag_q <= 1'b0;
            n_flag_q <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            sat_q    <= sat_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            c_flag_q <= c_flag_d;
            v_flag_q <= v_flag_d;
            z_flag_q <= z_flag_d;
            n_flag_q <= n_flag_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready         = ready_q;
    assign o_valid         = valid_q;
    assign o_result        = result_q;
    assign o_carry_flag    = c_flag_q;
    assign o_overflow_flag = v_flag_q;
    assign o_zero_flag     = z_flag_q;
    assign o_negative_flag = n_flag_q;

endmodule

// File: tb/tb_chunked_add_sub_unit.sv
// Directed bench for chunked_add_sub_unit (32-bit bus, 8-bit chunks).
module tb_chunked_add_sub_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_operand1 = '0;
    logic [31:0] i_operand2 = '0;
    logic        i_sub = 1'b0;
    logic        i_saturate = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_carry_flag;
    logic        o_overflow_flag;
    logic        o_zero_flag;
    logic        o_negative_flag;

    int n_checks = 0;
    int n_errors = 0;

    chunked_add_sub_unit #(
        .BUS_WIDTH   (32),
        .CHUNK_WIDTH (8),
        .SATURATE_EN (1'b1)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_operand1      (i_operand1),
        .i_operand2      (i_operand2),
        .i_sub           (i_sub),
        .i_saturate      (i_saturate),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_result        (o_result),
        .o_carry_flag    (o_carry_flag),
        .o_overflow_flag (o_overflow_flag),
        .o_zero_flag     (o_zero_flag),
        .o_negative_flag (o_negative_flag)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sat;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_flags(input string name, input logic [31:0] res,
                               input logic c, input logic v, input logic z, input logic n);
        check({name, " result"}, 64'(o_result), 64'(res));
        check({name, " C"}, 64'(o_carry_flag), 64'(c));
        check({name, " V"}, 64'(o_overflow_flag), 64'(v));
        check({name, " Z"}, 64'(o_zero_flag), 64'(z));
        check({name, " N"}, 64'(o_negative_flag), 64'(n));
    endtask

    // Wait (bounded) until o_ready, sampled 1 time unit after a rising edge.
    task automatic wait_ready(input string name);
        int guard = 0;
        while (!o_ready && guard < 20) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        if (!o_ready) check({name, " ready timeout"}, 64'(o_ready), 64'd1);
    endtask

    // Launch one request; returns cycles from accepting edge to o_valid.
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic sat, output int lat);
        wait_ready(name);
        i_operand1 = a;
        i_operand2 = b;
        i_sub      = sub;
        i_saturate = sat;
        i_valid    = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid    = 1'b0;
        i_operand1 = $urandom;
        i_operand2 = $urandom;
        i_sub      = ~sub;
        i_saturate = ~sat;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(posedge i_clk);
            #1;
            if (!o_valid) lat++;
        end
        if (!o_valid) check({name, " valid timeout"}, 64'(o_valid), 64'd1);
    endtask

    // Complete the output handshake and confirm the unit returns to idle.
    task automatic retire(input string name);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check({name, " valid drop"}, 64'(o_valid), 64'd0);
        check({name, " ready back"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        //          a             b            sub   sat   res          C     V     Z     N
        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b0, 32'h22222221, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h00000003, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values, then idle hold after release.
        #2;
        i_rst = 1'b1;
        #1;
        check("rst valid", 64'(o_valid), 64'd0);
        check("rst ready", 64'(o_ready), 64'd1);
        check_flags("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("idle valid", 64'(o_valid), 64'd0);
        check("idle ready", 64'(o_ready), 64'd1);
        check_flags("idle", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table of directed operations.
        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(nm, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat, lat);
            check({nm, " latency"}, 64'(lat), 64'd4);
            check({nm, " ready busy"}, 64'(o_ready), 64'd0);
            check_flags(nm, vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n);
            retire(nm);
        end

        // Back-pressure: hold the result for 10 cycles with a stray request.
        issue("hold", 32'h00000001, 32'h00000002, 1'b0, 1'b0, lat);
        check("hold latency", 64'(lat), 64'd4);
        held = o_result;
        check("hold result", 64'(held), 64'h3);
        i_operand1 = 32'hDEADBEEF;
        i_operand2 = 32'h11111111;
        i_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk);
            #1;
            check($sformatf("hold%0d valid", c), 64'(o_valid), 64'd1);
            check($sformatf("hold%0d ready", c), 64'(o_ready), 64'd0);
            check($sformatf("hold%0d result", c), 64'(o_result), 64'h3);
            check($sformatf("hold%0d flags", c),
                  64'({o_carry_flag, o_overflow_flag, o_zero_flag, o_negative_flag}), 64'd0);
        end
        i_valid = 1'b0;
        retire("hold");
        check("hold result kept", 64'(o_result), 64'h3);

        // Reset in the middle of CALC (slice index 2).
        issue("pre", 32'h00000010, 32'h00000020, 1'b0, 1'b0, lat);
        retire("pre");
        wait_ready("midrst");
        i_operand1 = 32'hFFFFFFFF;
        i_operand2 = 32'hFFFFFFFF;
        i_sub = 1'b0;
        i_saturate = 1'b1;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("midrst valid", 64'(o_valid), 64'd0);
        check("midrst ready", 64'(o_ready), 64'd1);
        check("midrst result", 64'(o_result), 64'h0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        issue("post", 32'h00000003, 32'h00000004, 1'b0, 1'b0, lat);
        check("post latency", 64'(lat), 64'd4);
        check_flags("post", 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b0);
        retire("post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
